// File: rtl/ps_seq_pkg.sv
// ps_seq_pkg: mode type and stage indices shared by the power-supply sequencer.
package ps_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        ON,
        RAMP_DN,
        FAULT
    } mode_t;

    localparam logic [2:0] STG_OFF = 3'd0;
    localparam logic [2:0] STG_CA  = 3'd1;
    localparam logic [2:0] STG_G1  = 3'd2;
    localparam logic [2:0] STG_G2  = 3'd3;
    localparam logic [2:0] STG_AN  = 3'd4;
    localparam logic [2:0] STG_DR  = 3'd5;
    localparam logic [2:0] STG_RF  = 3'd6;

endpackage

// File: rtl/ps_step_timer.sv
// ps_step_timer: saturating dwell counter; done once a stage has been held STEP_CYCLES cycles.
module ps_step_timer #(
    parameter int STEP_CYCLES = 1000,
    parameter int TIMER_W     = $clog2(STEP_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != TIMER_W'(STEP_CYCLES))
            count <= count + 1'b1;
    end

    // The edge that changes stage is the STEP_CYCLES-th edge spent in it.
    assign done = count >= TIMER_W'(STEP_CYCLES - 1);

endmodule

// File: rtl/ps_sequencer.sv
// ps_sequencer: staged power-supply enable sequencer with fault latch.
// Define PS_SEQ_STAGGER_DOWN_EN for a stepped reverse shutdown; otherwise stop drops all supplies at once.
module ps_sequencer
    import ps_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 1000,
    parameter int TIMER_W     = $clog2(STEP_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_fault_clr,
    input  logic       i77_I_AN_HIGH,
    input  logic       i47_Emergency,
    input  logic       i38_Not_Alarm,
    output logic       o34_CA_PS_Control,
    output logic       o25_G1_PS_Control,
    output logic       o24_G2_PS_Control,
    output logic       o32_Anode_PS_Control,
    output logic       o36_DR_AMP_Control,
    output logic       o37_RF_PERMIT_TED_Control,
    output logic [2:0] o_stage,
    output logic       o_fault,
    output logic       o_ready
);

`ifdef PS_SEQ_STAGGER_DOWN_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    mode_t      mode, mode_n;
    logic [2:0] stage, stage_n;
    logic [5:0] en, en_n;
    logic       fault_in, step_done, timer_clr;

    assign fault_in  = i47_Emergency | ~i77_I_AN_HIGH;
    assign timer_clr = (stage_n != stage) || (mode_n != mode);

    ps_step_timer #(
        .STEP_CYCLES(STEP_CYCLES),
        .TIMER_W    (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clr),
        .enable(mode == RAMP_UP || mode == RAMP_DN),
        .done  (step_done)
    );

    always_comb begin
        mode_n  = mode;
        stage_n = stage;
        if (fault_in) begin
            mode_n  = FAULT;
            stage_n = STG_OFF;
        end else begin
            case (mode)
                IDLE: if (i_start && !i_stop && i38_Not_Alarm) begin
                    mode_n  = RAMP_UP;
                    stage_n = STG_CA;
                end
                RAMP_UP: if (i_stop) begin
                    mode_n  = RAMP_DN;
                    stage_n = STAGGER ? stage - 3'd1 : STG_OFF;
                end else if (step_done) begin
                    stage_n = stage + 3'd1;
                    mode_n  = (stage == STG_DR) ? ON : RAMP_UP;
                end
                ON: if (i_stop) begin
                    mode_n  = RAMP_DN;
                    stage_n = STAGGER ? stage - 3'd1 : STG_OFF;
                end
                RAMP_DN: if (stage == STG_OFF)
                    mode_n = IDLE;
                else if (STAGGER && step_done)
                    stage_n = stage - 3'd1;
                FAULT: if (i_fault_clr && i38_Not_Alarm)
                    mode_n = IDLE;
                default: begin
                    mode_n  = IDLE;
                    stage_n = STG_OFF;
                end
            endcase
        end
    end

    always_comb begin
        en_n = '0;
        for (int k = 0; k < 6; k++)
            en_n[k] = (mode_n != FAULT) && (stage_n > 3'(k));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= IDLE;
            stage   <= STG_OFF;
            en      <= '0;
            o_fault <= 1'b0;
            o_ready <= 1'b0;
        end else begin
            mode    <= mode_n;
            stage   <= stage_n;
            en      <= en_n;
            o_fault <= mode_n == FAULT;
            o_ready <= mode_n == ON;
        end
    end

    assign o_stage                   = stage;
    assign o34_CA_PS_Control         = en[0];
    assign o25_G1_PS_Control         = en[1];
    assign o24_G2_PS_Control         = en[2];
    assign o32_Anode_PS_Control      = en[3];
    assign o36_DR_AMP_Control        = en[4];
    assign o37_RF_PERMIT_TED_Control = en[5];

endmodule

// File: tb/tb_ps_sequencer.sv
// tb_ps_sequencer: vector table, hand-written corner sequences and a randomized run against a cycle model.
module tb_ps_sequencer;

    localparam int STEP = 4;
`ifdef PS_SEQ_STAGGER_DOWN_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif
    localparam int P_IDLE = 0, P_UP = 1, P_ON = 2, P_DN = 3, P_FLT = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic i_start = 0, i_stop = 0, i_fault_clr = 0, i77 = 1, i47 = 0, i38 = 1;
    logic ca, g1, g2, an, dr, rf, o_fault, o_ready;
    logic [2:0] o_stage;
    logic [5:0] en;
    int tests = 0, fails = 0;

    assign en = {rf, dr, an, g2, g1, ca};

    always #5 clk = ~clk;

    ps_sequencer #(.STEP_CYCLES(STEP)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_fault_clr(i_fault_clr),
        .i77_I_AN_HIGH(i77), .i47_Emergency(i47), .i38_Not_Alarm(i38),
        .o34_CA_PS_Control(ca), .o25_G1_PS_Control(g1), .o24_G2_PS_Control(g2),
        .o32_Anode_PS_Control(an), .o36_DR_AMP_Control(dr), .o37_RF_PERMIT_TED_Control(rf),
        .o_stage(o_stage), .o_fault(o_fault), .o_ready(o_ready)
    );

    typedef struct {
        bit start, stop, clr, an_ok, emg, na;
        int n;
        int stage;
        bit fault, ready;
    } vec_t;

    vec_t tbl[16];

    // Reference model: phase, stage and cycles spent in the current stage.
    int m_ph, m_st, m_dw;

    function automatic logic [5:0] therm(input int s, input bit f);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = !f && (s > k);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_start = 0; i_stop = 0; i_fault_clr = 0; i77 = 1; i47 = 0; i38 = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            m_ph = P_IDLE; m_st = 0; m_dw = 0;
        end else if (i47 || !i77) begin
            m_ph = P_FLT; m_st = 0; m_dw = 0;
        end else if (m_ph == P_IDLE) begin
            if (i_start && !i_stop && i38) begin m_ph = P_UP; m_st = 1; m_dw = 0; end
        end else if (m_ph == P_UP || m_ph == P_ON) begin
            if (i_stop) begin
                m_ph = P_DN; m_st = STAGGER ? m_st - 1 : 0; m_dw = 0;
            end else if (m_ph == P_UP) begin
                m_dw++;
                if (m_dw == STEP) begin
                    m_st++; m_dw = 0;
                    if (m_st == 6) m_ph = P_ON;
                end
            end
        end else if (m_ph == P_DN) begin
            if (m_st == 0) m_ph = P_IDLE;
            else if (STAGGER) begin
                m_dw++;
                if (m_dw == STEP) begin m_st--; m_dw = 0; end
            end
        end else if (i_fault_clr && i38) begin
            m_ph = P_IDLE;
        end
    endtask

    initial begin
        int rise[6];
        int rf_fall, ca_fall, ready_rise;

        tbl[0]  = '{0, 0, 0, 1, 0, 1,  1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 0,  1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 0, 1,  1, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 1,  3, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 1,  1, 2, 0, 0};
        tbl[5]  = '{1, 0, 0, 1, 0, 1,  4, 3, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1,  1, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1,  2, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 1,  1, 0, 1, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 0,  1, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 1,  1, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 0, 1,  1, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 0, 1, 20, 6, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 0, 1, 10, 6, 0, 1};
        tbl[14] = '{0, 1, 0, 1, 1, 1,  1, 0, 1, 0};
        tbl[15] = '{0, 0, 1, 1, 0, 1,  1, 0, 0, 0};

        do_reset();
        chk("reset_state", {en, o_stage, o_fault, o_ready}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            i_start = tbl[i].start; i_stop = tbl[i].stop; i_fault_clr = tbl[i].clr;
            i77 = tbl[i].an_ok; i47 = tbl[i].emg; i38 = tbl[i].na;
            for (int c = 0; c < tbl[i].n; c++) tick();
            chk($sformatf("tbl%0d_stage", i), 32'(o_stage), 32'(tbl[i].stage));
            chk($sformatf("tbl%0d_en", i), 32'(en), 32'(therm(tbl[i].stage, tbl[i].fault)));
            chk($sformatf("tbl%0d_fault", i), 32'(o_fault), 32'(tbl[i].fault));
            chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].ready));
        end

        // Ramp timing: each enable rises STEP cycles after the previous one.
        idle_inputs();
        do_reset();
        foreach (rise[k]) rise[k] = -1;
        ready_rise = -1;
        i_start = 1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            i_start = 0;
            for (int k = 0; k < 6; k++) if (en[k] && rise[k] < 0) rise[k] = c;
            if (o_ready && ready_rise < 0) ready_rise = c;
        end
        for (int k = 0; k < 6; k++) chk($sformatf("rise_en%0d", k), 32'(rise[k]), 32'(1 + STEP * k));
        chk("ready_with_rf", 32'(ready_rise), 32'(1 + STEP * 5));

        // Stop from ON: RF drops first; CA drops immediately or after 5 steps.
        rf_fall = -1; ca_fall = -1;
        i_stop = 1;
        for (int d = 1; d <= 30 && ca_fall < 0; d++) begin
            tick();
            if (!rf && rf_fall < 0) rf_fall = d;
            if (!ca && ca_fall < 0) ca_fall = d;
            if (d == 1) chk("stop_first_cycle_en", 32'(en), STAGGER ? 32'h1f : 32'h0);
        end
        chk("stop_rf_fall", 32'(rf_fall), 32'd1);
        chk("stop_ca_fall", 32'(ca_fall), STAGGER ? 32'(1 + 5 * STEP) : 32'd1);
        i_stop = 0;
        tick();
        i_start = 1;
        tick();
        i_start = 0;
        chk("restart_after_stop", 32'(o_stage), 32'd1);

        // Reset mid-ramp: no staged shutdown.
        for (int c = 0; c < 2 * STEP; c++) tick();
        chk("midramp_stage", 32'(o_stage), 32'd3);
        reset = 1;
        tick();
        chk("midramp_reset", {en, o_stage, o_ready}, 32'd0);
        reset = 0;

        // Reset overrides a latched fault.
        i47 = 1;
        tick();
        chk("emergency_fault", 32'(o_fault), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        i47 = 0;
        chk("reset_clears_fault", {en, o_stage, o_fault}, 32'd0);

        // Randomized run against the model.
        idle_inputs();
        do_reset();
        m_ph = P_IDLE; m_st = 0; m_dw = 0;
        for (int c = 0; c < 4000; c++) begin
            i_start = ($urandom % 4) == 0;
            i_stop = ($urandom % 40) == 0;
            i_fault_clr = ($urandom % 6) == 0;
            i77 = ($urandom % 80) != 0;
            i47 = ($urandom % 150) == 0;
            i38 = ($urandom % 8) != 0;
            reset = ($urandom % 700) == 0;
            @(posedge clk);
            model_step();
            #1;
            chk("random", {en, o_stage, o_fault, o_ready},
                32'({therm(m_st, m_ph == P_FLT), 3'(m_st), m_ph == P_FLT, m_ph == P_ON}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
